// File: rtl/bsg_cover_rx.sv
// Receive side of the coverage drain stream: rebuilds width_p-bit entries from
// MSW-first beats, hands them downstream, and tracks burst counts and protocol errors.
module bsg_cover_rx #(
    parameter int width_p     = 40,
    parameter int out_width_p = 32,
    parameter int els_p       = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [out_width_p-1:0] data_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    output logic                   last_o,
    input  logic                   ready_i,
    output logic [7:0]             burst_cnt_o,
    output logic                   burst_done_o,
    output logic [2:0]             err_o,
    input  logic                   clear_err_i
);
    localparam int div_lp    = (width_p + out_width_p - 1) / out_width_p;
    localparam int pad_lp    = div_lp * out_width_p - width_p;
    localparam int asm_w_lp  = div_lp * out_width_p;
    localparam int beat_w_lp = (div_lp > 1) ? $clog2(div_lp) : 1;

    typedef enum logic {COLLECT, OUTPUT} state_e;

    state_e                 state_reg, state_next;
    logic [beat_w_lp-1:0]   beat_reg;
    logic [asm_w_lp-1:0]    asm_reg, asm_shift;
    logic [7:0]             entry_reg, entry_inc;
    logic [width_p-1:0]     data_reg;
    logic                   last_reg, done_reg;
    logic [7:0]             burst_cnt_reg;
    logic [2:0]             err_reg, err_next;
    logic                   pad_nz, accept, final_beat, framing, entry_done, handoff;

    // The assembly register holds earlier (more significant) words above the new beat.
    generate
        if (div_lp == 1) begin : g_single
            assign asm_shift = data_i;
        end else begin : g_multi
            assign asm_shift = {asm_reg[asm_w_lp-out_width_p-1:0], data_i};
        end
        if (pad_lp > 0) begin : g_pad
            assign pad_nz = |asm_shift[asm_w_lp-1 -: pad_lp];
        end else begin : g_nopad
            assign pad_nz = 1'b0;
        end
    endgenerate

    assign accept     = (state_reg == COLLECT) && v_i;
    assign final_beat = (beat_reg == beat_w_lp'(div_lp - 1));
    assign framing    = accept && last_i && !final_beat;
    assign entry_done = accept && final_beat;
    assign handoff    = (state_reg == OUTPUT) && ready_i;
    assign entry_inc  = (entry_reg == 8'hFF) ? 8'hFF : entry_reg + 8'd1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_reg <= COLLECT;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (entry_done) state_next = OUTPUT;
            OUTPUT:  if (ready_i)    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Error events take priority over a same-cycle clear.
    always_comb begin
        err_next = clear_err_i ? 3'b000 : err_reg;
        if (framing)
            err_next[0] = 1'b1;
        if (entry_done && pad_nz)
            err_next[2] = 1'b1;
        if (handoff && ((last_reg && entry_inc != 8'(els_p)) ||
                        (!last_reg && entry_inc == 8'(els_p))))
            err_next[1] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_reg      <= '0;
            asm_reg       <= '0;
            entry_reg     <= '0;
            data_reg      <= '0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
            burst_cnt_reg <= '0;
            err_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= err_next;
            if (framing) begin
                beat_reg  <= '0;
                asm_reg   <= '0;
                entry_reg <= '0;
            end else if (entry_done) begin
                beat_reg <= '0;
                asm_reg  <= '0;
                data_reg <= asm_shift[width_p-1:0];
                last_reg <= last_i;
            end else if (accept) begin
                beat_reg <= beat_reg + 1'b1;
                asm_reg  <= asm_shift;
            end
            if (handoff) begin
                if (last_reg) begin
                    burst_cnt_reg <= entry_inc;
                    done_reg      <= 1'b1;
                    entry_reg     <= '0;
                end else begin
                    entry_reg <= entry_inc;
                end
            end
        end
    end

    assign ready_o      = (state_reg == COLLECT);
    assign v_o          = (state_reg == OUTPUT);
    assign data_o       = data_reg;
    assign last_o       = last_reg;
    assign burst_cnt_o  = burst_cnt_reg;
    assign burst_done_o = done_reg;
    assign err_o        = err_reg;
endmodule
